// File: rtl/geofence_collector.sv
// Collects geofence results into a tagged FWFT FIFO for a host reader and
// keeps running object, inside-count, inside-area and max-area statistics.
module geofence_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SUM_W = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gf_valid,
  input  logic             gf_is_inside,
  input  logic [21:0]      gf_area,
  input  logic             clr_stats,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] rd_obj_id,
  output logic             rd_is_inside,
  output logic [21:0]      rd_area,
  output logic [CNT_W-1:0] obj_cnt,
  output logic [CNT_W-1:0] inside_cnt,
  output logic [SUM_W-1:0] inside_area_sum,
  output logic [21:0]      max_area,
  output logic             overflow
);

  localparam int unsigned AREA_W = 22;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned ENT_W  = CNT_W + 1 + AREA_W;
  localparam int unsigned SW1    = SUM_W + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;

  logic             full, do_pop, do_push, drop;
  logic [ENT_W-1:0] entry, head_nxt;
  logic [CW-1:0]    count_nxt;
  logic [CNT_W-1:0] obj_base, ins_base, obj_nxt, ins_nxt;
  logic [SUM_W-1:0] sum_base, sum_nxt;
  logic [SW1-1:0]   sum_ext;
  logic [21:0]      max_base, max_nxt;
  logic             ovf_nxt;

  // FIFO control, next head entry and statistics update
  always_comb begin
    full      = (count == CW'(DEPTH));
    do_pop    = rd_valid & rd_ready;
    do_push   = gf_valid & (~full | do_pop);
    drop      = gf_valid & full & ~do_pop;
    count_nxt = CW'(count + CW'(do_push) - CW'(do_pop));

    obj_base  = clr_stats ? '0 : obj_cnt;
    ins_base  = clr_stats ? '0 : inside_cnt;
    sum_base  = clr_stats ? '0 : inside_area_sum;
    max_base  = clr_stats ? '0 : max_area;
    entry     = {obj_base, gf_is_inside, gf_area};

    // Head register tracks whatever entry sits at the read pointer after this edge
    head_nxt  = {rd_obj_id, rd_is_inside, rd_area};
    if (do_pop) begin
      if (count == CW'(1)) begin
        if (do_push) head_nxt = entry;
      end else begin
        head_nxt = mem[AW'(rptr + AW'(1))];
      end
    end else if (!rd_valid && do_push) begin
      head_nxt = entry;
    end

    obj_nxt = obj_base;
    ins_nxt = ins_base;
    sum_nxt = sum_base;
    max_nxt = max_base;
    ovf_nxt = (clr_stats ? 1'b0 : overflow) | drop;
    sum_ext = SW1'(sum_base) + SW1'(gf_area);
    if (gf_valid) begin
      obj_nxt = CNT_W'(obj_base + CNT_W'(1));
      if (gf_is_inside) begin
        if (ins_base != {CNT_W{1'b1}}) ins_nxt = CNT_W'(ins_base + CNT_W'(1));
        sum_nxt = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      end
      if (gf_area > max_base) max_nxt = gf_area;
    end
  end

  // Storage is not reset; occupancy and pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr            <= '0;
      rptr            <= '0;
      count           <= '0;
      rd_valid        <= 1'b0;
      rd_obj_id       <= '0;
      rd_is_inside    <= 1'b0;
      rd_area         <= '0;
      obj_cnt         <= '0;
      inside_cnt      <= '0;
      inside_area_sum <= '0;
      max_area        <= '0;
      overflow        <= 1'b0;
    end else begin
      if (do_push) wptr <= AW'(wptr + AW'(1));
      if (do_pop)  rptr <= AW'(rptr + AW'(1));
      count           <= count_nxt;
      rd_valid        <= (count_nxt != '0);
      {rd_obj_id, rd_is_inside, rd_area} <= head_nxt;
      obj_cnt         <= obj_nxt;
      inside_cnt      <= ins_nxt;
      inside_area_sum <= sum_nxt;
      max_area        <= max_nxt;
      overflow        <= ovf_nxt;
    end
  end

endmodule
